sop_shared_eval: RTL and testbench
==================================

# sop_shared_eval

Runtime-configurable, pipelined evaluator for shared-logic sum-of-products (SOP) approximate circuits. It generalises the fixed, per-candidate SOP netlists to parameterised input, output and product counts. Literal masks and the product-to-output activation matrix are loaded through a config port, so no resynthesis is needed. It sits in the evaluation harness between the stimulus source and the result sink, and monitors error against the exact circuit's outputs.

## Interface
Parameters:
- N_IN, 4: number of primary inputs.
- N_OUT, 2: number of outputs.
- N_PROD, 7: number of shared product terms.
- ET, 1: error threshold. Unsigned absolute output difference allowed without counting as a violation.
- CW, 16: width of the violation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- cfg_we  in  1  config write request.
- cfg_ready  out  1  config write accepted this cycle when high with cfg_we.
- cfg_addr  in  clog2(N_PROD)  product index being written.
- cfg_used  in  N_IN  bit i=1: literal on input i is present in the product.
- cfg_pol  in  N_IN  bit i=1: positive literal; 0: negated literal.
- cfg_act  in  N_OUT  bit j=1: product feeds output j.
- cfg_oe_we  in  1  write the output-enable register (same acceptance rule as cfg_we).
- cfg_oe  in  N_OUT  output enable; a disabled output is forced to 0.
- in_valid, in_ready  in/out  1  input handshake.
- in_data  in  N_IN  in_data[i] is input i.
- in_ref  in  N_OUT  exact-circuit output for the same vector; travels with the data.
- out_valid, out_ready  out/in  1  output handshake.
- out_data  out  N_OUT  out_data[j] is output j.
- clr_stats  in  1  clear the error statistics.
- err_cnt  out  CW  saturating count of transfers with diff > ET.
- err_max  out  N_OUT+1  maximum observed diff.

## Operation
- Product p = AND over i with used[p][i] of (pol[p][i] ? in[i] : ~in[i]). If used[p] == 0, the product evaluates to 0, not 1.
- out[j] = oe[j] & OR over p of (prod[p] & act[p][j]).
- Config storage is N_PROD × (2·N_IN + N_OUT) registers plus oe. All are 0 after reset, so every output reads 0.
- cfg_ready = pipeline empty (both stage valids low). When a config write is accepted, in_ready is forced low in that cycle. Config has priority over data.
- cfg_addr ≥ N_PROD: the write is accepted and ignored.
- Stage 1 registers the N_PROD product bits, and carries in_ref and a valid bit.
- Stage 2 registers the OR-ed out_data and in_ref. Its valid bit drives out_valid.
- Each stage loads when it is empty or its contents are being taken downstream in the same cycle. in_ready = !s1_valid | s1 advancing (full throughput, bubble-free).
- Error monitor, evaluated on each out_valid & out_ready transfer:
  - diff = |out_data − in_ref|, with both operands read as unsigned N_OUT-bit integers, computed at N_OUT+1 bits.
  - If diff > ET, err_cnt increments, saturating at 2^CW−1.
  - err_max = max(err_max, diff).
- clr_stats zeroes err_cnt and err_max. If it coincides with a transfer, the clear wins and that transfer's contribution is dropped.

## Timing
- Latency is 2 cycles from an accepted input to out_valid, with no output stall. Throughput is 1 vector per cycle.
- out_data and out_valid are register outputs. out_data is held stable while out_valid & !out_ready.
- Backpressure: with out_ready low, at most 2 vectors are accepted before in_ready drops.
- Statistics update on the clock edge after the transfer cycle.
- Reset values:
  - out_valid=0, out_data=0, err_cnt=0, err_max=0.
  - in_ready=1 and cfg_ready=1 in the first cycle after reset.
  - All config registers 0.
- Reset mid-operation flushes both stages; in-flight vectors are lost and do not count toward the statistics.
- A config change only affects vectors accepted after the write cycle. This holds by construction, since the pipeline is empty at the time of the write.

## Test plan
- Reset, then drive in_data=4'b0101 with all config at 0 → out_data=2'b00 after 2 cycles; err_cnt=0.
- Load 7 products:
  - p0={in2,in3}, p1={~in1,in3}, p2={~in0,in3}, p3={in2,~in3}, p4={in1,~in3}, p5={~in0,~in3}, p6={in0,~in2}.
  - act0 = p0,p2,p3,p4,p5; act1 = p1,p6; oe=2'b11.
  - Stream 4'b0000 then 4'b0001 → out_data 2'b01 then 2'b10, in consecutive cycles.
- Same config, in_ref=2'b11 with in_data=4'b0000 (out 2'b01, diff 2 > ET=1) → err_cnt=1, err_max=2. Then in_ref=2'b00 with in_data=4'b0000 (diff 1) → err_cnt stays 1.
- Hold out_ready=0 with in_valid=1 → exactly 2 vectors accepted, in_ready=0 afterwards. Release → outputs appear in order with no loss or duplication.
- Assert cfg_we with in_valid high while the pipeline is full → cfg_ready=0 until the pipeline drains. On the acceptance cycle in_ready=0. A write with cfg_addr=7 changes nothing.
- Preload err_cnt to 2^CW−1 (or use CW=2) and force repeated violations → the counter stays saturated. Assert clr_stats coincident with a violating transfer → both statistics read 0 afterwards.

Source files
------------

// File: rtl/sop_shared_eval.sv
// Two-stage evaluator for shared-product SOP circuits with runtime-loaded literal
// masks and activation matrix, plus an error monitor against the exact outputs.
module sop_shared_eval #(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 2,
   parameter int N_PROD = 7,
   parameter int ET     = 1,
   parameter int CW     = 16,
   localparam int AW    = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   output logic              cfg_ready,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [N_IN-1:0]   cfg_used,
   input  logic [N_IN-1:0]   cfg_pol,
   input  logic [N_OUT-1:0]  cfg_act,
   input  logic              cfg_oe_we,
   input  logic [N_OUT-1:0]  cfg_oe,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IN-1:0]   in_data,
   input  logic [N_OUT-1:0]  in_ref,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_OUT-1:0]  out_data,
   input  logic              clr_stats,
   output logic [CW-1:0]     err_cnt,
   output logic [N_OUT:0]    err_max
);

   localparam logic [N_OUT:0] ET_V = (N_OUT+1)'(ET);

   logic [N_IN-1:0]  used_mem [N_PROD];
   logic [N_IN-1:0]  pol_mem  [N_PROD];
   logic [N_OUT-1:0] act_mem  [N_PROD];
   logic [N_OUT-1:0] oe_reg;

   logic              s1_valid;
   logic [N_PROD-1:0] s1_prod;
   logic [N_OUT-1:0]  s1_ref;
   logic              s2_valid;
   logic [N_OUT-1:0]  s2_data;
   logic [N_OUT-1:0]  s2_ref;

   logic              cfg_accept;
   logic              s2_load;
   logic              xfer;
   logic [N_PROD-1:0] prod;
   logic [N_OUT-1:0]  or_out;
   logic [N_OUT:0]    diff;

   // Config writes only land on an empty pipeline, so in-flight vectors never see a change.
   assign cfg_ready  = !s1_valid && !s2_valid;
   assign cfg_accept = (cfg_we || cfg_oe_we) && cfg_ready;
   assign s2_load    = !s2_valid || out_ready;
   assign in_ready   = (!s1_valid || s2_load) && !cfg_accept;
   assign out_valid  = s2_valid;
   assign out_data   = s2_data;
   assign xfer       = s2_valid && out_ready;

   // An empty literal mask yields 0 rather than the AND identity.
   always_comb begin
      prod = '0;
      for (int p = 0; p < N_PROD; p++) begin
         prod[p] = (|used_mem[p]) & (&((in_data ~^ pol_mem[p]) | ~used_mem[p]));
      end
   end

   always_comb begin
      or_out = '0;
      for (int p = 0; p < N_PROD; p++) begin
         for (int j = 0; j < N_OUT; j++) begin
            or_out[j] = or_out[j] | (s1_prod[p] & act_mem[p][j]);
         end
      end
      or_out = or_out & oe_reg;
   end

   always_comb begin
      diff = '0;
      if (s2_data >= s2_ref) diff = {1'b0, s2_data} - {1'b0, s2_ref};
      else                   diff = {1'b0, s2_ref} - {1'b0, s2_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < N_PROD; p++) begin
            used_mem[p] <= '0;
            pol_mem[p]  <= '0;
            act_mem[p]  <= '0;
         end
         oe_reg <= '0;
      end else if (cfg_accept) begin
         if (cfg_oe_we) oe_reg <= cfg_oe;
         if (cfg_we) begin
            // Out-of-range addresses match no entry and are silently dropped.
            for (int p = 0; p < N_PROD; p++) begin
               if (cfg_addr == AW'(p)) begin
                  used_mem[p] <= cfg_used;
                  pol_mem[p]  <= cfg_pol;
                  act_mem[p]  <= cfg_act;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_prod  <= '0;
         s1_ref   <= '0;
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_ref   <= '0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
            s1_prod  <= prod;
            s1_ref   <= in_ref;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
         if (s2_load) begin
            s2_valid <= s1_valid;
            s2_data  <= or_out;
            s2_ref   <= s1_ref;
         end
      end
   end

   // A clear coinciding with a transfer discards that transfer's contribution.
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         err_cnt <= '0;
         err_max <= '0;
      end else if (xfer) begin
         if (diff > ET_V && err_cnt != {CW{1'b1}}) err_cnt <= err_cnt + CW'(1);
         if (diff > err_max) err_max <= diff;
      end
   end

endmodule

// File: tb/tb_sop_shared_eval.sv
// Randomized self-checking bench for sop_shared_eval against a behavioural SOP,
// handshake and error-statistics model.
module tb_sop_shared_eval;

   localparam int N_IN   = 4;
   localparam int N_OUT  = 2;
   localparam int N_PROD = 7;
   localparam int ET     = 1;
   localparam int CW     = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_we = 1'b0;
   logic             cfg_ready;
   logic [2:0]       cfg_addr = '0;
   logic [3:0]       cfg_used = '0;
   logic [3:0]       cfg_pol = '0;
   logic [1:0]       cfg_act = '0;
   logic             cfg_oe_we = 1'b0;
   logic [1:0]       cfg_oe = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       in_data = '0;
   logic [1:0]       in_ref = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [1:0]       out_data;
   logic             clr_stats = 1'b0;
   logic [CW-1:0]    err_cnt;
   logic [2:0]       err_max;

   always #5 clk = ~clk;

   sop_shared_eval #(
      .N_IN(N_IN), .N_OUT(N_OUT), .N_PROD(N_PROD), .ET(ET), .CW(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
      .cfg_used(cfg_used), .cfg_pol(cfg_pol), .cfg_act(cfg_act),
      .cfg_oe_we(cfg_oe_we), .cfg_oe(cfg_oe),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ref(in_ref),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .clr_stats(clr_stats), .err_cnt(err_cnt), .err_max(err_max)
   );

   typedef struct {
      logic [1:0] out;
      logic [1:0] rf;
      int         acc;
   } item_t;

   item_t      q[$];
   logic [3:0] mUsed [N_PROD];
   logic [3:0] mPol  [N_PROD];
   logic [1:0] mAct  [N_PROD];
   logic [1:0] mOe;
   int         mCnt, mMax;
   int         cyc = 0;
   int         accCount = 0;
   int         checks = 0;
   int         fails = 0;

   // Reference SOP straight from the literal/activation definition.
   function automatic logic [1:0] modelOut(input logic [3:0] d);
      logic [1:0] r;
      logic hit;
      r = '0;
      for (int p = 0; p < N_PROD; p++) begin
         hit = (mUsed[p] != 4'd0);
         for (int i = 0; i < N_IN; i++)
            if (mUsed[p][i] && (d[i] != mPol[p][i])) hit = 1'b0;
         for (int j = 0; j < N_OUT; j++)
            if (hit && mAct[p][j] && mOe[j]) r[j] = 1'b1;
      end
      return r;
   endfunction

   task automatic modelReset();
      q.delete();
      for (int p = 0; p < N_PROD; p++) begin
         mUsed[p] = '0;
         mPol[p]  = '0;
         mAct[p]  = '0;
      end
      mOe  = '0;
      mCnt = 0;
      mMax = 0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: drive, check mid-cycle against the model, advance the model, clock.
   task automatic applyStimulus(input logic iv, input logic [3:0] d, input logic [1:0] r,
                                input logic ordy, input logic clr);
      logic expCfgAcc, expValid, acc, xfer;
      int n, a, b, diff;
      item_t it;
      in_valid = iv; in_data = d; in_ref = r; out_ready = ordy; clr_stats = clr;
      #4;
      n = q.size();
      expCfgAcc = (cfg_we || cfg_oe_we) && (n == 0);
      expValid = 1'b0;
      if (n > 0) expValid = (cyc - q[0].acc) >= 2;
      checkOutput("cfg_ready", 32'(cfg_ready), 32'(n == 0));
      checkOutput("in_ready", 32'(in_ready), 32'(!expCfgAcc && (n < 2 || ordy)));
      checkOutput("out_valid", 32'(out_valid), 32'(expValid));
      if (out_valid && n > 0) checkOutput("out_data", 32'(out_data), 32'(q[0].out));
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer && n > 0) begin
         it = q.pop_front();
         a = int'(it.out);
         b = int'(it.rf);
         diff = (a > b) ? a - b : b - a;
         if (!clr) begin
            if (diff > ET && mCnt < (1 << CW) - 1) mCnt++;
            if (diff > mMax) mMax = diff;
         end
      end
      if (clr) begin
         mCnt = 0;
         mMax = 0;
      end
      if (acc) begin
         q.push_back('{modelOut(d), r, cyc});
         accCount++;
      end
      if (expCfgAcc) begin
         if (cfg_we && cfg_addr < 3'(N_PROD)) begin
            mUsed[cfg_addr] = cfg_used;
            mPol[cfg_addr]  = cfg_pol;
            mAct[cfg_addr]  = cfg_act;
         end
         if (cfg_oe_we) mOe = cfg_oe;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (expCfgAcc) begin
         cfg_we = 1'b0;
         cfg_oe_we = 1'b0;
      end
      checkOutput("err_cnt", 32'(err_cnt), 32'(mCnt));
      checkOutput("err_max", 32'(err_max), 32'(mMax));
   endtask

   task automatic doReset();
      rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; cfg_oe_we = 1'b0;
      clr_stats = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
      modelReset();
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
      checkOutput("rst_err_max", 32'(err_max), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
   endtask

   task automatic writeCfg(input logic we, input logic oewe, input logic [2:0] addr,
                           input logic [3:0] used, input logic [3:0] pol,
                           input logic [1:0] act, input logic [1:0] oe);
      cfg_addr = addr; cfg_used = used; cfg_pol = pol; cfg_act = act; cfg_oe = oe;
      cfg_we = we; cfg_oe_we = oewe;
      for (int k = 0; k < 20 && (cfg_we || cfg_oe_we); k++)
         applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 1'b0);
      if (cfg_we || cfg_oe_we) begin
         checkOutput("cfg_timeout", 32'd0, 32'd1);
         cfg_we = 1'b0;
         cfg_oe_we = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int bpStart;
      doReset();

      // All-zero config: every output reads 0 with two-cycle latency.
      applyStimulus(1'b1, 4'b0101, 2'b00, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);
      checkOutput("zero_cfg_valid", 32'(out_valid), 32'd1);
      checkOutput("zero_cfg_data", 32'(out_data), 32'd0);
      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);
      checkOutput("zero_cfg_errcnt", 32'(err_cnt), 32'd0);

      writeCfg(1, 0, 3'd0, 4'b1100, 4'b1100, 2'b01, 2'b00);
      writeCfg(1, 0, 3'd1, 4'b1010, 4'b1000, 2'b10, 2'b00);
      writeCfg(1, 0, 3'd2, 4'b1001, 4'b1000, 2'b01, 2'b00);
      writeCfg(1, 0, 3'd3, 4'b1100, 4'b0100, 2'b01, 2'b00);
      writeCfg(1, 0, 3'd4, 4'b1010, 4'b0010, 2'b01, 2'b00);
      writeCfg(1, 0, 3'd5, 4'b1001, 4'b0000, 2'b01, 2'b00);
      writeCfg(1, 0, 3'd6, 4'b0101, 4'b0001, 2'b10, 2'b00);
      writeCfg(0, 1, 3'd0, 4'b0000, 4'b0000, 2'b00, 2'b11);

      applyStimulus(1'b1, 4'b0000, 2'b01, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'b0001, 2'b10, 1'b1, 1'b0);
      checkOutput("plan_out0", 32'(out_data), 32'd1);
      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);
      checkOutput("plan_out1", 32'(out_data), 32'd2);
      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);

      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b1);
      applyStimulus(1'b1, 4'b0000, 2'b11, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);
      checkOutput("viol_cnt", 32'(err_cnt), 32'd1);
      checkOutput("viol_max", 32'(err_max), 32'd2);
      applyStimulus(1'b1, 4'b0000, 2'b00, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);
      checkOutput("within_et_cnt", 32'(err_cnt), 32'd1);

      // Counter saturation, then a clear that collides with a violating transfer.
      for (int k = 0; k < 10; k++) applyStimulus(1'b1, 4'b0000, 2'b11, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);
      checkOutput("sat_cnt", 32'(err_cnt), 32'((1 << CW) - 1));
      applyStimulus(1'b1, 4'b0000, 2'b11, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'b0000, 2'b11, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b1);
      checkOutput("clr_win_cnt", 32'(err_cnt), 32'd0);
      checkOutput("clr_win_max", 32'(err_max), 32'd0);
      repeat (2) applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);

      bpStart = accCount;
      for (int k = 0; k < 4; k++)
         applyStimulus(1'b1, 4'($urandom), 2'($urandom), 1'b0, 1'b0);
      checkOutput("bp_accepts", 32'(accCount - bpStart), 32'd2);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      repeat (3) applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);

      // Config request against a full pipeline, then accepted alongside a data request.
      applyStimulus(1'b1, 4'b0011, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b1000, 2'b00, 1'b0, 1'b0);
      cfg_we = 1'b1; cfg_addr = 3'd7; cfg_used = 4'hF; cfg_pol = 4'hF; cfg_act = 2'b11;
      repeat (3) applyStimulus(1'b1, 4'b1111, 2'b00, 1'b0, 1'b0);
      repeat (2) applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);
      checkOutput("cfg_ready_drained", 32'(cfg_ready), 32'd1);
      applyStimulus(1'b1, 4'b1111, 2'b00, 1'b1, 1'b0);
      checkOutput("cfg_we_consumed", 32'(cfg_we), 32'd0);
      for (int k = 0; k < 16; k++)
         applyStimulus(1'b1, 4'(k), 2'b00, 1'b1, 1'b0);
      repeat (2) applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);

      for (int k = 0; k < 400; k++) begin
         if (!cfg_we && !cfg_oe_we && $urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 3) == 0) begin
               cfg_oe_we = 1'b1; cfg_oe = 2'($urandom);
            end else begin
               cfg_we = 1'b1; cfg_addr = 3'($urandom); cfg_used = 4'($urandom);
               cfg_pol = 4'($urandom); cfg_act = 2'($urandom);
            end
         end
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
      end
      cfg_we = 1'b0; cfg_oe_we = 1'b0;
      repeat (3) applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);

      // Reset with both stages full: in-flight vectors vanish.
      writeCfg(0, 1, 3'd0, 4'b0000, 4'b0000, 2'b00, 2'b11);
      writeCfg(1, 0, 3'd0, 4'b0001, 4'b0001, 2'b11, 2'b00);
      applyStimulus(1'b1, 4'b0001, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'b0001, 2'b00, 1'b0, 1'b0);
      doReset();
      repeat (3) applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'b0001, 2'b00, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);
      checkOutput("post_rst_cfg_zero", 32'(out_data), 32'd0);
      applyStimulus(1'b0, 4'b0000, 2'b00, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
